// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
//
// Command-bus arbiter for the SDRAM controller. Four sub-blocks compete for
// the single command/bank/address bus: initialization, auto-refresh, write
// and read. Only one of them owns the bus at a time.
//
// Ownership rules:
//   - Initialization owns the bus from reset until init_end is seen.
//   - After that, refresh has priority over data traffic.
//   - When write and read are both pending, they take turns.
//   - Once a block is granted, it keeps the bus until its own *_end pulse.
//     There is no preemption.
//   - Every release returns to an idle (ARBIT) cycle that drives NOP, so
//     grants are always separated by at least one NOP.
//
// Ports:
//   sys_clk, sys_rst_n            clock, asynchronous active-low reset
//   init_end                      initialization finished (level, sticky)
//   init_cmd/_ba/_addr            init block command bus
//   aref_req, aref_end            refresh request (level) / done (pulse)
//   aref_cmd/_ba/_addr            refresh block command bus
//   wr_req, wr_end                write request (level) / done (pulse)
//   wr_cmd/_ba/_addr              write block command bus
//   wr_dq_oe, wr_data             write block DQ enable and data
//   rd_req, rd_end                read request (level) / done (pulse)
//   rd_cmd/_ba/_addr              read block command bus
//   aref_en, wr_en, rd_en         registered grants, high while owned
//   sdram_cs_n.._we_n             command pins (cmd bits 3..0)
//   sdram_ba, sdram_addr          bank / address pins
//   sdram_dq_oe, sdram_dq_o       DQ output enable / output data
// -----------------------------------------------------------------------------
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,

  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [11:0] init_addr,

  input  logic        aref_req,
  input  logic        aref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [11:0] aref_addr,

  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [11:0] wr_addr,
  input  logic        wr_dq_oe,
  input  logic [15:0] wr_data,

  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [11:0] rd_addr,

  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,

  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic        sdram_dq_oe,
  output logic [15:0] sdram_dq_o
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t state_reg;
  // Set when the most recent completed data grant was a write. It is used to
  // break a write/read tie in favour of the other side. Refresh grants leave
  // it untouched, so the alternation carries across a refresh.
  logic   last_wr_reg;

  // ---------------------------------------------------------------------------
  // State machine with registered grants.
  // The grant flags are updated on the same edge as the state, so each flag
  // tracks its state exactly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= ST_INIT;
      last_wr_reg <= 1'b0;
      aref_en     <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (init_end) begin
            state_reg <= ST_ARBIT;
          end
        end

        ST_ARBIT: begin
          if (aref_req) begin
            state_reg <= ST_AREF;
            aref_en   <= 1'b1;
          end else if (wr_req && (!rd_req || !last_wr_reg)) begin
            // Write goes if it is alone, or if it is a tie and read went last.
            state_reg <= ST_WRITE;
            wr_en     <= 1'b1;
          end else if (rd_req) begin
            state_reg <= ST_READ;
            rd_en     <= 1'b1;
          end
        end

        // Only the owner's own end pulse releases the bus. End pulses from
        // other blocks are ignored.
        ST_AREF: begin
          if (aref_end) begin
            state_reg <= ST_ARBIT;
            aref_en   <= 1'b0;
          end
        end

        ST_WRITE: begin
          if (wr_end) begin
            state_reg   <= ST_ARBIT;
            wr_en       <= 1'b0;
            last_wr_reg <= 1'b1;
          end
        end

        ST_READ: begin
          if (rd_end) begin
            state_reg   <= ST_ARBIT;
            rd_en       <= 1'b0;
            last_wr_reg <= 1'b0;
          end
        end

        default: begin
          state_reg <= ST_INIT;
          aref_en   <= 1'b0;
          wr_en     <= 1'b0;
          rd_en     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bus mux.
  // The select comes only from the state register, so a request input never
  // reaches the pins combinationally.
  // ---------------------------------------------------------------------------
  logic [3:0]  cmd_mux;
  logic [1:0]  ba_mux;
  logic [11:0] addr_mux;

  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = 2'b11;
    addr_mux = 12'hFFF;
    case (state_reg)
      ST_INIT: begin
        cmd_mux  = init_cmd;
        ba_mux   = init_ba;
        addr_mux = init_addr;
      end
      ST_AREF: begin
        cmd_mux  = aref_cmd;
        ba_mux   = aref_ba;
        addr_mux = aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = wr_cmd;
        ba_mux   = wr_ba;
        addr_mux = wr_addr;
      end
      ST_READ: begin
        cmd_mux  = rd_cmd;
        ba_mux   = rd_ba;
        addr_mux = rd_addr;
      end
      default: begin
        cmd_mux  = CMD_NOP;
        ba_mux   = 2'b11;
        addr_mux = 12'hFFF;
      end
    endcase
  end

  assign sdram_cs_n  = cmd_mux[3];
  assign sdram_ras_n = cmd_mux[2];
  assign sdram_cas_n = cmd_mux[1];
  assign sdram_we_n  = cmd_mux[0];
  assign sdram_ba    = ba_mux;
  assign sdram_addr  = addr_mux;

  // ---------------------------------------------------------------------------
  // DQ drive.
  // The write block can drive DQ only while it owns the bus. Output data is
  // forced to zero whenever the output enable is low, so the data lines stay
  // quiet when DQ is not being driven.
  // ---------------------------------------------------------------------------
  assign sdram_dq_oe = (state_reg == ST_WRITE) && wr_dq_oe;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_dq
      assign sdram_dq_o[gi] = wr_data[gi] & sdram_dq_oe;
    end
  endgenerate

endmodule
